i281_code_loader: RTL and testbench

Byte-stream program loader for the i281 CPU. Sits directly upstream of the code memory write port: receives a framed program image one byte at a time, assembles 16-bit instruction words, writes them to consecutive code memory addresses from 0, and holds the CPU while a load is in progress. Reports a one-cycle completion pulse and a sticky frame/checksum error flag.

---
 rtl/i281_code_loader.sv | 119 +++++++++++
 tb/tb_i281_code_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i281_code_loader.sv
// Byte-stream program loader for the i281 code memory: parses SYNC/COUNT/words/CSUM
// frames, writes assembled 16-bit words from address 0 and stalls the CPU meanwhile.
module i281_code_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [8:0] CAPACITY  = 9'(2 ** ADDR_W);

  logic [2:0]      state;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] idx_next;
  logic [7:0]      acc;
  logic [8:0]      rx_ext;
  logic            xfer;
  logic            count_bad;

  assign rx_ready  = (state != S_WRITE);
  assign xfer      = rx_valid & rx_ready;
  assign idx_next  = idx + 1'b1;
  assign rx_ext    = {1'b0, rx_data};
  assign count_bad = (rx_data == 8'd0) || (rx_ext > CAPACITY);

  // Index/count carry one extra bit so a full 2^ADDR_W-word frame terminates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      idx        <= '0;
      acc        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && rx_data == SYNC_BYTE) begin
            state      <= S_COUNT;
            cpu_hold   <= 1'b1;
            load_error <= 1'b0;
            idx        <= '0;
            acc        <= '0;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            if (count_bad) begin
              state      <= S_IDLE;
              load_error <= 1'b1;
            end else begin
              state <= S_HI;
              count <= rx_data[ADDR_W:0];
              acc   <= rx_data;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            state                   <= S_LO;
            wr_data[WORD_W-1 -: 8]  <= rx_data;
            acc                     <= acc + rx_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            state        <= S_WRITE;
            wr_data[7:0] <= rx_data;
            acc          <= acc + rx_data;
            wr_en        <= 1'b1;
            wr_addr      <= idx[ADDR_W-1:0];
          end
        end
        S_WRITE: begin
          idx   <= idx_next;
          state <= (idx_next == count) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          if (xfer) begin
            state <= S_IDLE;
            if (rx_data == acc) begin
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              load_error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i281_code_loader.sv
// Directed bench for i281_code_loader: frame parsing, writes, checksum and error paths.
module tb_i281_code_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [5:0]  log_addr [0:255];
  logic [15:0] log_data [0:255];

  i281_code_loader #(.ADDR_W(6), .WORD_W(16)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  // Write/done monitor sampled mid-cycle
  always @(negedge clock) begin
    if (reset && wr_en) begin
      if (wr_cnt < 256) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (reset && load_done) done_cnt = done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 8) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 8) check("ready_timeout", 32'(guard), 32'd0);
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    check({tag, "_wr_data"},    32'(wr_data),    32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    check({tag, "_load_done"},  32'(load_done),  32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    int base;
    int dbase;
    logic [7:0] acc;
    logic [7:0] hi;
    logic [7:0] lo;

    // Reset state
    #12;
    check_reset_vals("rst");
    @(posedge clock); #1;
    reset = 1'b1;
    idle(1);

    // Non-SYNC bytes in IDLE are ignored
    send(8'h00);
    send(8'h13);
    check("idle_hold", 32'(cpu_hold), 32'd0);
    check("idle_wr",   32'(wr_cnt),   32'd0);
    check("idle_err",  32'(load_error), 32'd0);

    // Single-word good frame
    send(8'hA5);
    check("f1_hold_after_sync", 32'(cpu_hold), 32'd1);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    check("f1_wr_en",    32'(wr_en),    32'd1);
    check("f1_rx_ready", 32'(rx_ready), 32'd0);
    check("f1_wr_addr",  32'(wr_addr),  32'd0);
    check("f1_wr_data",  32'(wr_data),  32'h1234);
    send(8'h47);
    check("f1_done",  32'(load_done),  32'd1);
    check("f1_hold",  32'(cpu_hold),   32'd0);
    check("f1_err",   32'(load_error), 32'd0);
    idle(1);
    check("f1_done_pulse", 32'(load_done), 32'd0);
    check("f1_wr_cnt", 32'(wr_cnt), 32'd1);

    // Two words, SYNC value as data
    base = wr_cnt;
    send(8'hA5);
    send(8'h02);
    send(8'hA5);
    send(8'h01);
    check("f2_w0_ready", 32'(rx_ready), 32'd0);
    send(8'hFF);
    send(8'hFF);
    check("f2_w1_ready", 32'(rx_ready), 32'd0);
    send(8'hA6);
    check("f2_done", 32'(load_done), 32'd1);
    check("f2_hold", 32'(cpu_hold),  32'd0);
    idle(1);
    check("f2_wr_cnt", 32'(wr_cnt - base), 32'd2);
    check("f2_a0", 32'(log_addr[base]),     32'd0);
    check("f2_d0", 32'(log_data[base]),     32'hA501);
    check("f2_a1", 32'(log_addr[base + 1]), 32'd1);
    check("f2_d1", 32'(log_data[base + 1]), 32'hFFFF);

    // Bad checksum, then recovery
    base  = wr_cnt;
    dbase = done_cnt;
    send(8'hA5);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    send(8'h00);
    check("f3_err",  32'(load_error), 32'd1);
    check("f3_hold", 32'(cpu_hold),   32'd1);
    check("f3_done", 32'(load_done),  32'd0);
    idle(1);
    check("f3_wr_cnt",   32'(wr_cnt - base),    32'd1);
    check("f3_done_cnt", 32'(done_cnt - dbase), 32'd0);
    send(8'hA5);
    check("f3r_err_clear", 32'(load_error), 32'd0);
    send(8'h01);
    send(8'h00);
    send(8'h05);
    send(8'h06);
    check("f3r_done", 32'(load_done),  32'd1);
    check("f3r_hold", 32'(cpu_hold),   32'd0);
    check("f3r_err",  32'(load_error), 32'd0);

    // COUNT out of range: 0 and 65
    base = wr_cnt;
    send(8'hA5);
    send(8'h00);
    check("n0_err",   32'(load_error), 32'd1);
    check("n0_hold",  32'(cpu_hold),   32'd1);
    check("n0_ready", 32'(rx_ready),   32'd1);
    send(8'hA5);
    check("n41_sync_clear", 32'(load_error), 32'd0);
    send(8'h41);
    check("n41_err",  32'(load_error), 32'd1);
    check("n41_hold", 32'(cpu_hold),   32'd1);
    send(8'h12);
    send(8'h34);
    idle(2);
    check("nbad_wr_cnt", 32'(wr_cnt - base), 32'd0);

    // Full 64-word frame
    base = wr_cnt;
    acc  = 8'd64;
    send(8'hA5);
    send(8'd64);
    for (int i = 0; i < 64; i++) begin
      hi = 8'(i);
      lo = 8'(8'h80 + i);
      acc = acc + hi + lo;
      send(hi);
      send(lo);
    end
    send(acc);
    check("f64_done", 32'(load_done),  32'd1);
    check("f64_hold", 32'(cpu_hold),   32'd0);
    check("f64_err",  32'(load_error), 32'd0);
    idle(1);
    check("f64_wr_cnt", 32'(wr_cnt - base), 32'd64);
    for (int i = 0; i < 64; i++) begin
      check("f64_addr", 32'(log_addr[base + i]), 32'(i));
      check("f64_data", 32'(log_data[base + i]), {16'd0, 8'(i), 8'(8'h80 + i)});
    end

    // Gapped 3-word frame interrupted by reset after the second word
    base  = wr_cnt;
    dbase = done_cnt;
    idle($urandom_range(0, 3)); send(8'hA5);
    idle($urandom_range(0, 3)); send(8'h03);
    idle($urandom_range(0, 3)); send(8'h11);
    idle($urandom_range(0, 3)); send(8'h22);
    idle($urandom_range(0, 3)); send(8'h33);
    idle($urandom_range(0, 3)); send(8'h44);
    check("gap_w1_wr_en", 32'(wr_en),   32'd1);
    check("gap_w1_data",  32'(wr_data), 32'h3344);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clock); #1;
    reset = 1'b1;
    idle(1);
    send(8'h55);
    send(8'h66);
    send(8'h33);
    idle(2);
    check("gap_wr_cnt",   32'(wr_cnt - base),    32'd2);
    check("gap_addr1",    32'(log_addr[base + 1]), 32'd1);
    check("gap_done_cnt", 32'(done_cnt - dbase), 32'd0);
    check("gap_hold",     32'(cpu_hold),         32'd0);
    check("gap_err",      32'(load_error),       32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
